conf_dir_predictor: RTL and testbench
=====================================

CONF_DIR_PREDICTOR -- requirements
Module: conf_dir_predictor

Interface
REQ-001 SHALL have parameter FETCH_WIDTH, default 2, lookup slots per cycle.
REQ-002 SHALL have parameter PHT_ENTRY_NUM, default 2048, power of two; IDX_W = log2(PHT_ENTRY_NUM).
REQ-003 SHALL have parameter GHR_WIDTH, default 5, global-history bits, range 1..IDX_W-1.
REQ-004 SHALL have parameter MODE, default 2, index scheme: 0 bimodal, 1 gshare, 2 GAp.
REQ-005 SHALL have ports clk in 1 (clock) and rst in 1 (reset); one clock, reset asynchronous active-high.
REQ-006 SHALL have ports lookup_valid in FETCH_WIDTH, lookup_is_br in FETCH_WIDTH, lookup_pc in FETCH_WIDTH x 32 (per-slot fetch request).
REQ-007 SHALL have ports pred_taken out FETCH_WIDTH and pred_ghr out GHR_WIDTH (registered prediction and the history used).
REQ-008 SHALL have ports recover_valid in 1, recover_ghr in GHR_WIDTH, recover_taken in 1 (mispredict repair).
REQ-009 SHALL have ports commit_valid in 1, commit_pc in 32, commit_ghr in GHR_WIDTH, commit_taken in 1 (training).
REQ-010 SHALL have port ready out 1, high once table initialisation completes.

Function
REQ-011 SHALL hold PHT_ENTRY_NUM 2-bit saturating counters; predict taken iff counter[1]=1.
REQ-012 SHALL index by pc[IDX_W+1:2] (MODE 0), pc[IDX_W+1:2] XOR zero-extended ghr (MODE 1), or {pc[IDX_W-GHR_WIDTH+1:2], ghr} (MODE 2).
REQ-013 SHALL read the PHT combinationally in cycle t and present pred_taken/pred_ghr at cycle t+1 (latency 1); slots with lookup_valid=0 give pred_taken=0.
REQ-014 SHALL use the group-start GHR for all slots of one lookup group.
REQ-015 SHALL, at end of lookup cycle, shift into GHR (LSB newest) the predicted bit of each valid branch slot in slot order, stopping after the first predicted-taken slot.
REQ-016 SHALL, on recover_valid, load GHR with {recover_ghr[GHR_WIDTH-2:0], recover_taken}; recovery overrides the same-cycle lookup shift.
REQ-017 SHALL, on commit_valid, index with commit_pc/commit_ghr and increment (taken) or decrement (not-taken) the counter, saturating at 3 and 0.
REQ-018 SHALL, when commit and lookup hit the same entry in one cycle, return the pre-update value (no bypass); the update is visible from t+1.
REQ-019 SHALL use FSM INIT->READY; INIT writes 2'b01 to one entry per cycle at a wrapping counter from 0; after entry PHT_ENTRY_NUM-1 go READY.
REQ-020 SHALL, in INIT, force ready=0, pred_taken=0, ignore commit, and not shift GHR on lookups; recover_valid still loads GHR.
REQ-021 SHALL never leave READY except via reset.

Reset
REQ-022 SHALL, on rst assertion, asynchronously set FSM=INIT, init counter=0, GHR=0, pred_taken=0, pred_ghr=0, ready=0.
REQ-023 SHALL restart initialisation from entry 0 if rst asserts mid-INIT or in READY.

Structure
REQ-024 SHALL take PHT_ENTRY_NUM, GHR_WIDTH and MODE defaults from the shared micro-architecture configuration package (CONF_PHT_ENTRY_NUM, CONF_BRANCH_GLOBAL_HISTORY_BIT_WIDTH, a new CONF_DIR_PRED_MODE replacing the predictor-select macros).
REQ-025 SHALL place typedefs PHT_IndexPath, PHT_CounterPath, BranchGlobalHistoryPath and enum DirPredMode in the shared branch-predictor types package.
REQ-026 SHALL implement index hashing in one sub-module, dir_pred_index_hash, instantiated FETCH_WIDTH+1 times (lookups and commit).

Verification
REQ-027 Reset, wait PHT_ENTRY_NUM cycles -> ready rises exactly at cycle 2048; every lookup during INIT returns pred_taken=0.
REQ-028 MODE 0, commit pc=0x100 taken twice, then lookup 0x100 -> pred_taken=1 one cycle later; third and fourth taken commits keep the counter at 3.
REQ-029 MODE 1, GHR=5'b00000, two branch slots predicted 0 then 1 -> GHR becomes 5'b00001; slot0 predicted 1 -> only one bit shifted.
REQ-030 Lookup and recover (recover_ghr=5'b10110, taken=1) in the same cycle -> GHR=5'b01101; lookup shift discarded.
REQ-031 MODE 2, GHR_WIDTH=5, pc=0x40 with ghr 5'b00011 vs 5'b00111 -> distinct entries {0x010,00011} and {0x010,00111} trained independently.
REQ-032 Assert rst at init counter 700 -> ready=0 immediately, initialisation restarts at 0, ready after 2048 further cycles.

Source files
------------

// File: rtl/conf_dir_predictor_pkg.sv
// Shared configuration and branch-predictor types for the conditional direction predictor.
// Holds the default table geometry, the index-scheme enum and the counter update helper.
package conf_dir_predictor_pkg;

    localparam int CONF_PHT_ENTRY_NUM                   = 2048;
    localparam int CONF_BRANCH_GLOBAL_HISTORY_BIT_WIDTH = 5;
    localparam int CONF_PHT_INDEX_BIT_WIDTH             = $clog2(CONF_PHT_ENTRY_NUM);

    typedef enum logic [1:0] {
        DIR_PRED_BIMODAL = 2'd0,
        DIR_PRED_GSHARE  = 2'd1,
        DIR_PRED_GAP     = 2'd2
    } DirPredMode;

    localparam DirPredMode CONF_DIR_PRED_MODE = DIR_PRED_GAP;

    typedef logic [CONF_PHT_INDEX_BIT_WIDTH-1:0]             PHT_IndexPath;
    typedef logic [1:0]                                      PHT_CounterPath;
    typedef logic [CONF_BRANCH_GLOBAL_HISTORY_BIT_WIDTH-1:0] BranchGlobalHistoryPath;

    typedef enum logic {
        DIR_PRED_ST_INIT  = 1'b0,
        DIR_PRED_ST_READY = 1'b1
    } DirPredState;

    localparam PHT_CounterPath PHT_COUNTER_INIT = 2'b01;

    // Two-bit saturating counter step towards the resolved direction.
    function automatic PHT_CounterPath pht_counter_update(input PHT_CounterPath cnt, input logic taken);
        PHT_CounterPath result;
        if (taken) begin
            result = (cnt == 2'b11) ? 2'b11 : cnt + 2'b01;
        end else begin
            result = (cnt == 2'b00) ? 2'b00 : cnt - 2'b01;
        end
        return result;
    endfunction

endpackage

// File: rtl/conf_dir_predictor_index_hash.sv
// PHT index hash: bimodal, gshare or GAp selection of pc and global history bits.
// One instance per lookup slot plus one for the commit port, so every path hashes identically.
module dir_pred_index_hash
    import conf_dir_predictor_pkg::*;
#(
    parameter int IDX_W     = CONF_PHT_INDEX_BIT_WIDTH,
    parameter int GHR_WIDTH = CONF_BRANCH_GLOBAL_HISTORY_BIT_WIDTH,
    parameter int MODE      = int'(CONF_DIR_PRED_MODE)
) (
    input  logic [31:0]          pc,
    input  logic [GHR_WIDTH-1:0] ghr,
    output logic [IDX_W-1:0]     idx
);

    logic unused_hash_bits_s;
    assign unused_hash_bits_s = ^{pc, ghr};

    // Index selection; the word-offset bits pc[1:0] never participate.
    always_comb begin
        idx = pc[IDX_W+1:2];
        case (MODE)
            int'(DIR_PRED_GSHARE): idx = pc[IDX_W+1:2] ^ {{(IDX_W-GHR_WIDTH){1'b0}}, ghr};
            int'(DIR_PRED_GAP):    idx = {pc[IDX_W-GHR_WIDTH+1:2], ghr};
            default:               idx = pc[IDX_W+1:2];
        endcase
    end

endmodule

// File: rtl/conf_dir_predictor.sv
// Conditional branch direction predictor: PHT of 2-bit counters, speculative global history,
// commit-time training and a one-entry-per-cycle table initialisation after reset.
module conf_dir_predictor
    import conf_dir_predictor_pkg::*;
#(
    parameter int FETCH_WIDTH   = 2,
    parameter int PHT_ENTRY_NUM = CONF_PHT_ENTRY_NUM,
    parameter int GHR_WIDTH     = CONF_BRANCH_GLOBAL_HISTORY_BIT_WIDTH,
    parameter int MODE          = int'(CONF_DIR_PRED_MODE)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [FETCH_WIDTH-1:0]      lookup_valid,
    input  logic [FETCH_WIDTH-1:0]      lookup_is_br,
    input  logic [FETCH_WIDTH-1:0][31:0] lookup_pc,
    output logic [FETCH_WIDTH-1:0]      pred_taken,
    output logic [GHR_WIDTH-1:0]        pred_ghr,
    input  logic                        recover_valid,
    input  logic [GHR_WIDTH-1:0]        recover_ghr,
    input  logic                        recover_taken,
    input  logic                        commit_valid,
    input  logic [31:0]                 commit_pc,
    input  logic [GHR_WIDTH-1:0]        commit_ghr,
    input  logic                        commit_taken,
    output logic                        ready
);

    localparam int               IDX_W    = $clog2(PHT_ENTRY_NUM);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PHT_ENTRY_NUM - 1);

    logic [1:0]           pht_r [PHT_ENTRY_NUM];
    DirPredState          state_r;
    DirPredState          state_next_s;
    logic [IDX_W-1:0]     init_cnt_r;
    logic [GHR_WIDTH-1:0] ghr_r;
    logic [GHR_WIDTH-1:0] ghr_walk_s;
    logic [GHR_WIDTH-1:0] ghr_next_s;
    logic                 walk_stop_s;
    logic                 shift_en_s;
    logic [IDX_W-1:0]     lookup_idx_s [FETCH_WIDTH];
    logic [FETCH_WIDTH-1:0] lookup_bit_s;
    logic [IDX_W-1:0]     commit_idx_s;
    logic                 wr_en_s;
    logic [IDX_W-1:0]     wr_idx_s;
    logic [1:0]           wr_data_s;

    // All slots of a group hash with the group-start history.
    for (genvar i = 0; i < FETCH_WIDTH; i++) begin : g_lookup
        dir_pred_index_hash #(.IDX_W(IDX_W), .GHR_WIDTH(GHR_WIDTH), .MODE(MODE)) u_lookup_hash (
            .pc  (lookup_pc[i]),
            .ghr (ghr_r),
            .idx (lookup_idx_s[i])
        );
        assign lookup_bit_s[i] = pht_r[lookup_idx_s[i]][1];
    end

    dir_pred_index_hash #(.IDX_W(IDX_W), .GHR_WIDTH(GHR_WIDTH), .MODE(MODE)) u_commit_hash (
        .pc  (commit_pc),
        .ghr (commit_ghr),
        .idx (commit_idx_s)
    );

    // FSM next state: INIT sweeps the table once, READY is terminal.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            DIR_PRED_ST_INIT: begin
                if (init_cnt_r == LAST_IDX) begin
                    state_next_s = DIR_PRED_ST_READY;
                end else begin
                    state_next_s = DIR_PRED_ST_INIT;
                end
            end
            DIR_PRED_ST_READY: state_next_s = DIR_PRED_ST_READY;
            default:           state_next_s = DIR_PRED_ST_INIT;
        endcase
    end

    // Single PHT write port: initialisation sweep or commit training.
    always_comb begin
        wr_en_s   = 1'b0;
        wr_idx_s  = commit_idx_s;
        wr_data_s = PHT_COUNTER_INIT;
        if (state_r == DIR_PRED_ST_INIT) begin
            wr_en_s   = 1'b1;
            wr_idx_s  = init_cnt_r;
            wr_data_s = PHT_COUNTER_INIT;
        end else if (commit_valid) begin
            wr_en_s   = 1'b1;
            wr_idx_s  = commit_idx_s;
            wr_data_s = pht_counter_update(pht_r[commit_idx_s], commit_taken);
        end else begin
            wr_en_s   = 1'b0;
        end
    end

    // Speculative history: shift predictions up to the first taken branch; recovery wins.
    always_comb begin
        ghr_walk_s  = ghr_r;
        walk_stop_s = 1'b0;
        shift_en_s  = 1'b0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            shift_en_s  = !walk_stop_s && lookup_valid[i] && lookup_is_br[i];
            ghr_walk_s  = shift_en_s ? GHR_WIDTH'({ghr_walk_s, lookup_bit_s[i]}) : ghr_walk_s;
            walk_stop_s = walk_stop_s | (shift_en_s & lookup_bit_s[i]);
        end
        if (recover_valid) begin
            ghr_next_s = GHR_WIDTH'({recover_ghr, recover_taken});
        end else if (state_r == DIR_PRED_ST_READY) begin
            ghr_next_s = ghr_walk_s;
        end else begin
            ghr_next_s = ghr_r;
        end
    end

    // Control state, history and registered prediction outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= DIR_PRED_ST_INIT;
            init_cnt_r <= '0;
            ghr_r      <= '0;
            pred_taken <= '0;
            pred_ghr   <= '0;
            ready      <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            init_cnt_r <= (state_r == DIR_PRED_ST_INIT) ? init_cnt_r + IDX_W'(1) : init_cnt_r;
            ghr_r      <= ghr_next_s;
            pred_taken <= (state_r == DIR_PRED_ST_READY) ? (lookup_valid & lookup_bit_s) : '0;
            pred_ghr   <= ghr_r;
            ready      <= (state_next_s == DIR_PRED_ST_READY);
        end
    end

    // Counter storage; contents are established by the INIT sweep rather than by reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            pht_r[wr_idx_s] <= wr_data_s;
        end
    end

endmodule

// File: tb/tb_conf_dir_predictor.sv
// Bench for conf_dir_predictor: three instances (bimodal, gshare, GAp) share stimulus and are
// compared every cycle against a table/arithmetic reference, plus hand-derived directed checks.
module tb_conf_dir_predictor;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [1:0]       lookup_valid = '0;
    logic [1:0]       lookup_is_br = '0;
    logic [1:0][31:0] lookup_pc = '0;
    logic             recover_valid = 1'b0;
    logic [4:0]       recover_ghr = '0;
    logic             recover_taken = 1'b0;
    logic             commit_valid = 1'b0;
    logic [31:0]      commit_pc = '0;
    logic [4:0]       commit_ghr = '0;
    logic             commit_taken = 1'b0;

    logic [1:0] pred_taken_w [3];
    logic [4:0] pred_ghr_w [3];
    logic       ready_w [3];

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    conf_dir_predictor #(.FETCH_WIDTH(2), .PHT_ENTRY_NUM(2048), .GHR_WIDTH(5), .MODE(0)) u_dut0 (
        .clk(clk), .rst(rst), .lookup_valid(lookup_valid), .lookup_is_br(lookup_is_br),
        .lookup_pc(lookup_pc), .pred_taken(pred_taken_w[0]), .pred_ghr(pred_ghr_w[0]),
        .recover_valid(recover_valid), .recover_ghr(recover_ghr), .recover_taken(recover_taken),
        .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_ghr(commit_ghr),
        .commit_taken(commit_taken), .ready(ready_w[0]));

    conf_dir_predictor #(.FETCH_WIDTH(2), .PHT_ENTRY_NUM(2048), .GHR_WIDTH(5), .MODE(1)) u_dut1 (
        .clk(clk), .rst(rst), .lookup_valid(lookup_valid), .lookup_is_br(lookup_is_br),
        .lookup_pc(lookup_pc), .pred_taken(pred_taken_w[1]), .pred_ghr(pred_ghr_w[1]),
        .recover_valid(recover_valid), .recover_ghr(recover_ghr), .recover_taken(recover_taken),
        .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_ghr(commit_ghr),
        .commit_taken(commit_taken), .ready(ready_w[1]));

    conf_dir_predictor #(.FETCH_WIDTH(2), .PHT_ENTRY_NUM(2048), .GHR_WIDTH(5), .MODE(2)) u_dut2 (
        .clk(clk), .rst(rst), .lookup_valid(lookup_valid), .lookup_is_br(lookup_is_br),
        .lookup_pc(lookup_pc), .pred_taken(pred_taken_w[2]), .pred_ghr(pred_ghr_w[2]),
        .recover_valid(recover_valid), .recover_ghr(recover_ghr), .recover_taken(recover_taken),
        .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_ghr(commit_ghr),
        .commit_taken(commit_taken), .ready(ready_w[2]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: counters as plain ints, index from pc arithmetic, history as an int.
    int   m_pht [3][2048];
    int   m_ghr [3];
    int   m_init [3];
    bit   m_ready [3];
    logic [1:0] e_pred [3];
    int   e_pghr [3];
    bit   e_ready [3];

    function automatic int idx_of(input int m, input logic [31:0] pc, input int g);
        int unsigned w;
        w = pc / 4;
        case (m)
            0:       return int'(w % 2048);
            1:       return int'((w ^ g) % 2048);
            default: return int'((w % 64) * 32 + g);
        endcase
    endfunction

    initial begin
        for (int m = 0; m < 3; m++) begin
            m_ghr[m] = 0; m_init[m] = 0; m_ready[m] = 0;
            e_pred[m] = '0; e_pghr[m] = 0; e_ready[m] = 0;
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int m = 0; m < 3; m++) begin
                m_ghr[m] = 0; m_init[m] = 0; m_ready[m] = 0;
                e_pred[m] = '0; e_pghr[m] = 0; e_ready[m] = 0;
            end
        end else begin
            for (int m = 0; m < 3; m++) begin
                int g;
                bit stop;
                bit b;
                int ci;
                int ix;
                g = m_ghr[m];
                stop = 0;
                e_pghr[m] = m_ghr[m];
                if (!m_ready[m]) begin
                    e_pred[m] = '0;
                    m_pht[m][m_init[m]] = 1;
                    m_init[m]++;
                    if (m_init[m] == 2048) m_ready[m] = 1;
                end else begin
                    for (int i = 0; i < 2; i++) begin
                        ix = idx_of(m, lookup_pc[i], m_ghr[m]);
                        b = (m_pht[m][ix] >= 2);
                        e_pred[m][i] = lookup_valid[i] && b;
                        if (!stop && lookup_valid[i] && lookup_is_br[i]) begin
                            g = (g * 2 + int'(b)) % 32;
                            if (b) stop = 1;
                        end
                    end
                    if (commit_valid) begin
                        ci = idx_of(m, commit_pc, int'(commit_ghr));
                        if (commit_taken) m_pht[m][ci] = (m_pht[m][ci] < 3) ? m_pht[m][ci] + 1 : 3;
                        else              m_pht[m][ci] = (m_pht[m][ci] > 0) ? m_pht[m][ci] - 1 : 0;
                    end
                end
                if (recover_valid) g = (int'(recover_ghr) * 2 + int'(recover_taken)) % 32;
                m_ghr[m] = g;
                e_ready[m] = m_ready[m];
            end
        end
    end

    // Cycle-by-cycle comparison away from the active edge.
    always @(negedge clk) begin
        for (int m = 0; m < 3; m++) begin
            chk($sformatf("ready_m%0d", m), 32'(ready_w[m]), 32'(e_ready[m]));
            chk($sformatf("pred_taken_m%0d", m), 32'(pred_taken_w[m]), 32'(e_pred[m]));
            chk($sformatf("pred_ghr_m%0d", m), 32'(pred_ghr_w[m]), e_pghr[m]);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        lookup_valid = '0; lookup_is_br = '0; lookup_pc = '0;
        recover_valid = 1'b0; recover_ghr = '0; recover_taken = 1'b0;
        commit_valid = 1'b0; commit_pc = '0; commit_ghr = '0; commit_taken = 1'b0;
    endtask

    task automatic rand_inputs();
        lookup_valid  = 2'($urandom_range(0, 3));
        lookup_is_br  = 2'($urandom_range(0, 3));
        lookup_pc[0]  = 32'h0000_1000 + 32'($urandom_range(0, 31) * 4);
        lookup_pc[1]  = 32'h0000_1000 + 32'($urandom_range(0, 31) * 4);
        recover_valid = ($urandom_range(0, 15) == 0);
        recover_ghr   = 5'($urandom_range(0, 31));
        recover_taken = 1'($urandom_range(0, 1));
        commit_valid  = 1'($urandom_range(0, 1));
        commit_pc     = 32'h0000_1000 + 32'($urandom_range(0, 31) * 4);
        commit_ghr    = 5'($urandom_range(0, 31));
        commit_taken  = 1'($urandom_range(0, 1));
    endtask

    task automatic commit(input logic [31:0] pc, input logic [4:0] g, input logic t);
        idle();
        commit_valid = 1'b1; commit_pc = pc; commit_ghr = g; commit_taken = t;
        step();
        idle();
    endtask

    task automatic recover(input logic [4:0] g, input logic t);
        idle();
        recover_valid = 1'b1; recover_ghr = g; recover_taken = t;
        step();
        idle();
    endtask

    task automatic lookup(input logic [1:0] v, input logic [1:0] br, input logic [31:0] pc0, input logic [31:0] pc1);
        idle();
        lookup_valid = v; lookup_is_br = br; lookup_pc[0] = pc0; lookup_pc[1] = pc1;
        step();
        idle();
    endtask

    task automatic wait_ready(input string name);
        int cycles;
        logic [1:0] nz;
        cycles = 0;
        nz = '0;
        while (!ready_w[2] && cycles < 3000) begin
            rand_inputs();
            step();
            cycles++;
            nz = nz | pred_taken_w[0] | pred_taken_w[1] | pred_taken_w[2];
        end
        idle();
        chk(name, 32'(cycles), 32'd2048);
        chk({name, "_init_pred_zero"}, 32'(nz), 32'd0);
    endtask

    initial begin
        idle();
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        wait_ready("ready_cycles");

        // Bimodal: two taken commits saturate-free to 3, extra commits must saturate.
        commit(32'h100, 5'd0, 1'b1);
        commit(32'h100, 5'd0, 1'b1);
        lookup(2'b01, 2'b00, 32'h100, 32'h0);
        chk("bimodal_taken", 32'(pred_taken_w[0][0]), 32'd1);
        commit(32'h100, 5'd0, 1'b1);
        commit(32'h100, 5'd0, 1'b1);
        commit(32'h100, 5'd0, 1'b0);
        commit(32'h100, 5'd0, 1'b0);
        lookup(2'b01, 2'b00, 32'h100, 32'h0);
        chk("bimodal_saturate", 32'(pred_taken_w[0][0]), 32'd0);

        // Gshare: not-taken then taken shifts two bits; taken slot0 stops the walk.
        commit(32'h204, 5'd0, 1'b1);
        commit(32'h204, 5'd0, 1'b1);
        recover(5'b00000, 1'b0);
        lookup(2'b11, 2'b11, 32'h200, 32'h204);
        chk("gshare_pred_pair", 32'(pred_taken_w[1]), 32'h2);
        chk("gshare_ghr_start", 32'(pred_ghr_w[1]), 32'h0);
        lookup(2'b00, 2'b00, 32'h0, 32'h0);
        chk("gshare_ghr_two_bits", 32'(pred_ghr_w[1]), 32'h01);
        recover(5'b00000, 1'b0);
        lookup(2'b11, 2'b11, 32'h204, 32'h200);
        chk("gshare_pred_first_taken", 32'(pred_taken_w[1]), 32'h1);
        lookup(2'b00, 2'b00, 32'h0, 32'h0);
        chk("gshare_ghr_one_bit", 32'(pred_ghr_w[1]), 32'h01);

        // Recovery in the same cycle as a lookup discards the lookup shift.
        idle();
        lookup_valid = 2'b11; lookup_is_br = 2'b11; lookup_pc[0] = 32'h204; lookup_pc[1] = 32'h200;
        recover_valid = 1'b1; recover_ghr = 5'b10110; recover_taken = 1'b1;
        step();
        idle();
        lookup(2'b00, 2'b00, 32'h0, 32'h0);
        chk("recover_override_m2", 32'(pred_ghr_w[2]), 32'h0D);
        chk("recover_override_m1", 32'(pred_ghr_w[1]), 32'h0D);

        // GAp: same pc with different history maps to independent counters.
        commit(32'h40, 5'b00011, 1'b1);
        commit(32'h40, 5'b00011, 1'b1);
        recover(5'b00001, 1'b1);
        lookup(2'b01, 2'b01, 32'h40, 32'h0);
        chk("gap_hist3_taken", 32'(pred_taken_w[2][0]), 32'd1);
        chk("gap_hist3_ghr", 32'(pred_ghr_w[2]), 32'h03);
        recover(5'b00011, 1'b1);
        lookup(2'b01, 2'b01, 32'h40, 32'h0);
        chk("gap_hist7_not_taken", 32'(pred_taken_w[2][0]), 32'd0);
        chk("gap_hist7_ghr", 32'(pred_ghr_w[2]), 32'h07);

        // Reset in READY clears ready without a clock edge.
        rst = 1'b1;
        #1;
        chk("ready_async_clear", 32'(ready_w[0]), 32'd0);
        step();
        rst = 1'b0;

        // Reset at init counter 700 restarts the sweep from entry 0.
        for (int i = 0; i < 700; i++) begin
            rand_inputs();
            step();
        end
        idle();
        rst = 1'b1;
        #1;
        chk("ready_low_mid_init", 32'(ready_w[2]), 32'd0);
        step();
        rst = 1'b0;
        wait_ready("ready_after_restart");

        for (int i = 0; i < 3000; i++) begin
            rand_inputs();
            step();
        end
        idle();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
